uart_rx_fifo: RTL

Memory-mapped UART receiver for the small-core SoC, placed at uart_rx_base_addr (0x1000004, 4-byte window) beside the UART transmitter. It oversamples the serial rx line in the CPU clock domain, deframes 8N1 characters at the configured baud rate, and queues received bytes in a small FIFO. The core reads the FIFO through the standard valid/ready memory port.

---
 rtl/uart_rx_fifo.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// Memory-mapped 8N1 UART receiver: oversampling deframer feeding a small byte FIFO.
// Reads return {ferr, ovr, nonempty, head}, pop the head, and clear the sticky flags.
module uart_rx_fifo #(
    parameter int clk_divider_bit = 43,
    parameter int buffer_depth    = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        uart_rx_valid,
    input  logic        uart_rx_instr,
    input  logic [31:0] uart_rx_addr,
    input  logic [31:0] uart_rx_wdata,
    input  logic [3:0]  uart_rx_wstrb,
    output logic [31:0] uart_rx_rdata,
    output logic        uart_rx_ready,
    input  logic        rx
);
    // state | meaning
    // IDLE  | line idle, waiting for rxs low
    // START | timing to mid start bit to confirm it
    // DATA  | sampling 8 data bits, LSB first
    // STOP  | sampling stop bit, push byte or flag framing error
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    localparam int CW = $clog2(clk_divider_bit);
    localparam int AW = $clog2(buffer_depth);

    state_t          r_state, w_state_nxt;
    logic            r_rx_meta, r_rxs;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_idx;
    logic [7:0]      r_shift;
    logic [7:0]      r_mem [buffer_depth];
    logic [AW-1:0]   r_wptr, r_rptr;
    logic [AW:0]     r_count;
    logic            r_ferr, r_ovr, r_ready;
    logic [31:0]     r_rdata;

    logic            w_cnt_last, w_cnt_mid;
    logic            w_push, w_set_ferr;
    logic            w_req, w_rd, w_pop, w_push_ok, w_set_ovr;
    logic            w_nonempty, w_full;
    logic [7:0]      w_head;
    logic            w_unused;

    assign w_unused = ^{uart_rx_instr, uart_rx_addr, uart_rx_wdata};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rxs     <= r_rx_meta;
        end
    end

    assign w_cnt_last = (r_cnt == CW'(clk_divider_bit - 1));
    assign w_cnt_mid  = (r_cnt == CW'(clk_divider_bit / 2));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (!r_rxs) w_state_nxt = S_START;
            S_START: if (w_cnt_mid) w_state_nxt = r_rxs ? S_IDLE : S_DATA;
            S_DATA:  if (w_cnt_last && r_idx == 3'd7) w_state_nxt = S_STOP;
            S_STOP:  if (w_cnt_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_push     = 1'b0;
        w_set_ferr = 1'b0;
        if (r_state == S_STOP && w_cnt_last) begin
            w_push     = r_rxs;
            w_set_ferr = !r_rxs;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            case (r_state)
                S_START: begin
                    r_cnt <= w_cnt_mid ? '0 : r_cnt + 1'b1;
                    r_idx <= '0;
                end
                S_DATA: begin
                    if (w_cnt_last) begin
                        r_cnt          <= '0;
                        r_shift[r_idx] <= r_rxs;
                        r_idx          <= r_idx + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP:  r_cnt <= w_cnt_last ? '0 : r_cnt + 1'b1;
                default: begin
                    r_cnt <= '0;
                    r_idx <= '0;
                end
            endcase
        end
    end

    // A valid still high during the ready cycle is the tail of the previous request.
    assign w_req      = uart_rx_valid && !r_ready;
    assign w_rd       = w_req && (uart_rx_wstrb == 4'd0);
    assign w_nonempty = (r_count != '0);
    assign w_full     = (r_count == (AW+1)'(buffer_depth));
    assign w_pop      = w_rd && w_nonempty;
    assign w_push_ok  = w_push && (!w_full || w_pop);
    assign w_set_ovr  = w_push && w_full && !w_pop;
    assign w_head     = w_nonempty ? r_mem[r_rptr] : 8'd0;

    always_ff @(posedge clock) begin
        if (w_push_ok) r_mem[r_wptr] <= r_shift;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
            r_ready <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (w_pop)     r_rptr <= r_rptr + 1'b1;
            if (w_push_ok && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push_ok && w_pop) r_count <= r_count - 1'b1;
            r_ferr  <= w_set_ferr || (r_ferr && !w_rd);
            r_ovr   <= w_set_ovr || (r_ovr && !w_rd);
            r_ready <= w_req;
            r_rdata <= w_rd ? {21'd0, r_ferr, r_ovr, w_nonempty, w_head} : 32'd0;
        end
    end

    assign uart_rx_ready = r_ready;
    assign uart_rx_rdata = r_rdata;
endmodule
